reorder_buffer_mc: RTL
======================

Name: reorder_buffer_mc

Overview:
Multi-commit, multi-writeback reorder buffer. It is the parametrised successor of the single-port ROB.
- Accepts one decoded instruction per cycle in program order.
- Accepts WB_PORTS out-of-order writebacks per cycle.
- Retires up to COMMIT_WIDTH completed instructions per cycle, in order.
- Raises a pipeline flush on a branch/jump mispredict or an unmasked exception.
- Sits between decode/rename and the architectural register file / control-register unit.

Parameters:
DATA, 32, writeback data width
ADDR, 32, PC width
ROB_DEPTH, 16, number of entries; must be a power of 2, >=4
COMMIT_WIDTH, 2, max retirements per cycle (1..4)
WB_PORTS, 2, writeback ports (1..4)
REG, 5, architectural register index width
EXP, 4, exception code width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dec_e_  in  1  decode valid (active-low)
dec_pc  in  ADDR  instruction PC
dec_rd_we  in  1  instruction writes rd
dec_rd  in  REG  destination register
dec_rob_id  out  log2(ROB_DEPTH)  tail index allocated to the current decode
rob_busy  out  1  ROB full; decode must stall
rob_count  out  log2(ROB_DEPTH)+1  occupied entries
wb_e_  in  WB_PORTS  per-port writeback valid (active-low)
wb_rob_id  in  WB_PORTS*log2(ROB_DEPTH)  target entry per port
wb_data  in  WB_PORTS*DATA  result per port
wb_exp_  in  WB_PORTS  exception flag (active-low)
wb_exp_code  in  WB_PORTS*EXP  exception cause
wb_pred_miss_  in  WB_PORTS  branch/jump mispredict (active-low)
creg_exp_mask  in  1  1 = exceptions masked
creg_tvec  in  ADDR  trap vector
commit_e_  out  COMMIT_WIDTH  per-slot commit valid (active-low); slot 0 is oldest
commit_pc  out  COMMIT_WIDTH*ADDR  committed PC per slot
commit_rd_we  out  COMMIT_WIDTH  register write enable per slot
commit_rd  out  COMMIT_WIDTH*REG  destination per slot
commit_data  out  COMMIT_WIDTH*DATA  result per slot
commit_rob_id  out  COMMIT_WIDTH*log2(ROB_DEPTH)  entry index per slot
flush_  out  1  pipeline flush pulse (active-low)
commit_exp_  out  1  exception commit (active-low)
commit_exp_code  out  EXP  exception cause
exp_handler_pc  out  ADDR  handler PC (creg_tvec latched)

Behaviour:
Reset:
- head = tail = 0, count = 0, all entries invalid.
- commit_e_ all 1, flush_ = 1, commit_exp_ = 1.
- commit_exp_code = 0, exp_handler_pc = 0, all commit data/pc/rd = 0.
- Reset asserted mid-operation discards everything at that edge.

Entry fields: valid, done, pc, rd_we, rd, data, exp, exp_code, miss.

Allocation:
- Occurs when dec_e_ = 0 and rob_busy = 0: the entry at tail is written with valid = 1, done = 0; tail advances mod ROB_DEPTH.
- dec_rob_id = tail, combinational.
- rob_busy = (count == ROB_DEPTH), combinational.
- Decode while busy is ignored.

Writeback:
- Per port with wb_e_ = 0 and a valid target entry: set done, data, exp, exp_code, miss at the edge.
- A writeback to an invalid entry is ignored.
- Two ports to the same id in one cycle: the lowest port wins.

Commit selection (combinational, outputs registered):
- Scan head..head+COMMIT_WIDTH-1.
- Take the longest contiguous prefix of valid && done entries.
- Stop after the first entry with miss, or with exp while creg_exp_mask = 0; that entry commits as the last slot of its group.
- Selected slots drive commit_e_ = 0 with their fields; unused slots drive commit_e_ = 1.
- head advances by k and entries are invalidated at the same edge.

Count:
- count_next = count + alloc - k.
- Allocation and commit in the same cycle are legal at any count, including full (k >= 1 frees space for next cycle only).

Latency: writeback in cycle n gives commit_e_ low in cycle n+2 at the earliest.

Flush:
- When the terminating entry (miss, or unmasked exp) is selected, flush_ = 0 is registered for exactly one cycle.
- At that same edge all entries are invalidated and head = tail = 0, count = 0.
- Allocations and writebacks presented in the selection cycle are discarded.
- Decode in the cycle flush_ is visible is accepted normally (dec_rob_id = 0).

Exception:
- Additionally commit_exp_ = 0, commit_exp_code = entry code, exp_handler_pc = creg_tvec, all for that one cycle.
- A masked exception commits as a normal instruction: no flush, commit_exp_ = 1.

Wrap-around: pointers wrap mod ROB_DEPTH; selection windows span the wrap.

Test Plan:
- Reset, then decode 3 instr (pc 0x100/0x104/0x108), write back ids 2,1,0 in successive cycles -> all commit in one or two groups in order; slot 0 pc 0x100; rob_count returns 0.
- Fill 16 entries -> rob_busy = 1, 17th decode ignored; write back id 0 -> entry 0 commits, then rob_busy = 0, next decode gets dec_rob_id = 0 (wrap).
- Two ports write ids 0 and 1 in the same cycle -> two cycles later commit_e_ = 2'b00, commit_rob_id {1,0}.
- id 1 written back with wb_pred_miss_ = 0, ids 0–3 all done -> ids 0 and 1 commit, flush_ = 0 for one cycle, ids 2–3 never commit, rob_count = 0, next dec_rob_id = 0.
- Exception code 2 on id 0, mask = 0, tvec 0xcafe0000 -> commit_exp_ = 0, code 2, exp_handler_pc 0xcafe0000, flush_ = 0; repeat with mask = 1 -> normal commit, no flush.
- Assert reset with 5 entries outstanding -> next cycle count 0, no commits follow.

Source files
------------

// File: rtl/reorder_buffer_mc.sv
// Multi-commit, multi-writeback reorder buffer: in-order allocate, out-of-order
// writeback, up to COMMIT_WIDTH in-order retirements per cycle, flush on mispredict/exception.
module reorder_buffer_mc #(
  parameter int  DATA         = 32,
  parameter int  ADDR         = 32,
  parameter int  ROB_DEPTH    = 16,
  parameter int  COMMIT_WIDTH = 2,
  parameter int  WB_PORTS     = 2,
  parameter int  REG          = 5,
  parameter int  EXP          = 4,
  localparam int IW           = $clog2(ROB_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_e_,
  input  logic [ADDR-1:0]              dec_pc,
  input  logic                         dec_rd_we,
  input  logic [REG-1:0]               dec_rd,
  output logic [IW-1:0]                dec_rob_id,
  output logic                         rob_busy,
  output logic [IW:0]                  rob_count,
  input  logic [WB_PORTS-1:0]          wb_e_,
  input  logic [WB_PORTS*IW-1:0]       wb_rob_id,
  input  logic [WB_PORTS*DATA-1:0]     wb_data,
  input  logic [WB_PORTS-1:0]          wb_exp_,
  input  logic [WB_PORTS*EXP-1:0]      wb_exp_code,
  input  logic [WB_PORTS-1:0]          wb_pred_miss_,
  input  logic                         creg_exp_mask,
  input  logic [ADDR-1:0]              creg_tvec,
  output logic [COMMIT_WIDTH-1:0]      commit_e_,
  output logic [COMMIT_WIDTH*ADDR-1:0] commit_pc,
  output logic [COMMIT_WIDTH-1:0]      commit_rd_we,
  output logic [COMMIT_WIDTH*REG-1:0]  commit_rd,
  output logic [COMMIT_WIDTH*DATA-1:0] commit_data,
  output logic [COMMIT_WIDTH*IW-1:0]   commit_rob_id,
  output logic                         flush_,
  output logic                         commit_exp_,
  output logic [EXP-1:0]               commit_exp_code,
  output logic [ADDR-1:0]              exp_handler_pc
);

  logic [ROB_DEPTH-1:0] valid_q, done_q, exp_q, miss_q, rd_we_q;
  logic [ADDR-1:0]      pc_q   [ROB_DEPTH];
  logic [REG-1:0]       rd_q   [ROB_DEPTH];
  logic [DATA-1:0]      data_q [ROB_DEPTH];
  logic [EXP-1:0]       code_q [ROB_DEPTH];
  logic [IW-1:0]        head_q, tail_q;
  logic [IW:0]          count_q;

  logic                    alloc;
  logic [IW-1:0]           wb_id    [WB_PORTS];
  logic [IW-1:0]           slot_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] sel;
  logic [IW:0]             k;
  logic                    sel_stop, term, term_exp;
  logic [EXP-1:0]          term_code;

  assign dec_rob_id = tail_q;
  assign rob_count  = count_q;
  assign rob_busy   = (count_q == (IW+1)'(ROB_DEPTH));
  assign alloc      = !dec_e_ && !rob_busy;

  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) wb_id[p] = wb_rob_id[p*IW +: IW];
    for (int s = 0; s < COMMIT_WIDTH; s++) slot_idx[s] = head_q + IW'(s);
  end

  // Commit window: longest done prefix from head, cut after a flush-causing entry.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    sel       = '0;
    k         = '0;
    sel_stop  = 1'b0;
    term      = 1'b0;
    term_exp  = 1'b0;
    term_code = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      if (!sel_stop) begin
        if (valid_q[slot_idx[s]] && done_q[slot_idx[s]]) begin
          sel[s] = 1'b1;
          k      = k + (IW+1)'(1);
          if (miss_q[slot_idx[s]] || (exp_q[slot_idx[s]] && !creg_exp_mask)) begin
            term      = 1'b1;
            term_exp  = exp_q[slot_idx[s]] && !creg_exp_mask;
            term_code = code_q[slot_idx[s]];
            sel_stop  = 1'b1;
          end
        end else begin
          sel_stop = 1'b1;
        end
      end
    end
  end

  // Control state and registered commit outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      valid_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_e_       <= '1;
      commit_pc       <= '0;
      commit_rd_we    <= '0;
      commit_rd       <= '0;
      commit_data     <= '0;
      commit_rob_id   <= '0;
      flush_          <= 1'b1;
      commit_exp_     <= 1'b1;
      commit_exp_code <= '0;
      exp_handler_pc  <= '0;
    end else begin
      for (int s = 0; s < COMMIT_WIDTH; s++) begin
        commit_e_[s]                   <= ~sel[s];
        commit_pc[s*ADDR +: ADDR]      <= sel[s] ? pc_q[slot_idx[s]]   : '0;
        commit_rd_we[s]                <= sel[s] & rd_we_q[slot_idx[s]];
        commit_rd[s*REG +: REG]        <= sel[s] ? rd_q[slot_idx[s]]   : '0;
        commit_data[s*DATA +: DATA]    <= sel[s] ? data_q[slot_idx[s]] : '0;
        commit_rob_id[s*IW +: IW]      <= sel[s] ? slot_idx[s]         : '0;
      end
      flush_      <= ~term;
      commit_exp_ <= ~term_exp;
      if (term_exp) begin
        commit_exp_code <= term_code;
        exp_handler_pc  <= creg_tvec;
      end
      if (term) begin
        // Same-cycle allocation and writebacks die with the flush.
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
          if (sel[s]) valid_q[slot_idx[s]] <= 1'b0;
        end
        if (alloc) begin
          valid_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + IW'(1);
        end
        head_q  <= head_q + k[IW-1:0];
        count_q <= count_q + (IW+1)'(alloc) - k;
      end
    end
  end

  // NOTE: the payload arrays carry no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    // Highest port first so the lowest port's write lands last and wins.
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      if (!wb_e_[p] && valid_q[wb_id[p]]) begin
        done_q[wb_id[p]] <= 1'b1;
        data_q[wb_id[p]] <= wb_data[p*DATA +: DATA];
        exp_q[wb_id[p]]  <= ~wb_exp_[p];
        code_q[wb_id[p]] <= wb_exp_code[p*EXP +: EXP];
        miss_q[wb_id[p]] <= ~wb_pred_miss_[p];
      end
    end
    if (alloc) begin
      done_q[tail_q]  <= 1'b0;
      exp_q[tail_q]   <= 1'b0;
      miss_q[tail_q]  <= 1'b0;
      pc_q[tail_q]    <= dec_pc;
      rd_we_q[tail_q] <= dec_rd_we;
      rd_q[tail_q]    <= dec_rd;
    end
  end

endmodule
